// File: rtl/inst_fetch_queue.sv
// Generic FIFO with synchronous flush and a head that is readable without popping.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is ignored when full and pop is ignored when empty; flush wins over both.
module ifq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic                     head_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push, do_pop;

    assign do_push  = push_vld && !flush && (cnt != FULL);
    assign do_pop   = pop_rdy && !flush && (cnt != '0);
    assign head_vld = (cnt != '0);
    assign head_dat = mem[rd_ptr];
    assign count    = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Instruction fetch front end: fetches from the shared SRAM port and queues words with PCs for decode.
// Latency: 2 cycles from an accepted request to the word on inst; 1 word/cycle sustained.
// Backpressure: requests stop while queued plus inflight words fill DEPTH; a denied grant holds the request.
module inst_fetch_queue #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 16,
    parameter int                 DEPTH    = 4,
    parameter int                 PC_STEP  = 1,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(16'h0800)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    input  logic                      mem_grant,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      inst_valid,
    output logic [DATA_W-1:0]         inst,
    output logic [ADDR_W-1:0]         inst_pc,
    input  logic                      inst_ready,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] word;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    typedef enum logic {BOOT, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, req_pc;
    logic              inflight, discard;
    logic              accept, push, pop;
    logic [LVL_W-1:0]  occ;
    entry_t            push_dat, head_dat;
    logic              head_vld;

    assign occ    = level + {{(LVL_W-1){1'b0}}, inflight};
    assign accept = mem_req && mem_grant;
    // A response arriving together with a redirect belongs to the old stream.
    assign push   = inflight && !discard && !redirect_valid;
    assign pop    = head_vld && inst_ready && !redirect_valid;

    assign push_dat.word = mem_rdata;
    assign push_dat.pc   = req_pc;

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN:  mem_req = !redirect_valid && (occ < DEPTH_L);
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= accept;
            // Marks a response still outstanding across a redirect as stale.
            discard  <= accept && redirect_valid;
            if (accept) req_pc <= fetch_pc;
            if (redirect_valid)
                fetch_pc <= redirect_pc;
            else if (accept)
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        end
    end

    ifq_fifo #(
        .WIDTH (DATA_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push_vld (push),
        .push_dat (push_dat),
        .pop_rdy  (pop),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (level)
    );

    assign mem_addr   = fetch_pc;
    assign inst_valid = head_vld;
    assign inst       = head_vld ? head_dat.word : NOP_WORD;
    assign inst_pc    = head_vld ? head_dat.pc : '0;
endmodule
